// File: rtl/modarith_3373_pkg.sv
// Shared constants and types for the q = 3373 modular arithmetic blocks.
// Barrett reduction uses mu = floor(2^24 / q) with a 12-bit shift on each side.
package modarith_3373_pkg;

  localparam int unsigned Q         = 3373;
  localparam int unsigned MU        = 4973;
  localparam int unsigned EXP_W     = 12;
  localparam int unsigned RED_SHIFT = 12;
  localparam logic [EXP_W-1:0] EXP  = 12'b1101_0010_1011;

  typedef logic [11:0] coeff_t;
  typedef logic [23:0] prod_t;

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_t;

endpackage

// File: rtl/barrett_red24_3373.sv
// Combinational Barrett reduction of a 24-bit product modulo 3373.
// The quotient estimate undershoots by at most 2, so two correction stages suffice.
module barrett_red24_3373
  import modarith_3373_pkg::*;
(
  input  logic [23:0] x,
  output logic [11:0] r
);

  logic [11:0] x_hi;
  logic [12:0] t;
  logic [13:0] r0;
  logic [13:0] r1;
  logic [13:0] r2;

  // The true remainder before correction is below 3q < 2^14, so 14-bit wraparound math is exact.
  always_comb begin
    x_hi = x[23:12];
    t    = 13'((25'(x_hi) * 25'(MU)) >> RED_SHIFT);
    r0   = x[13:0] - 14'(t * Q);
    r1   = (r0 >= 14'(Q)) ? (r0 - 14'(Q)) : r0;
    r2   = (r1 >= 14'(Q)) ? (r1 - 14'(Q)) : r1;
    r    = 12'(r2);
  end

endmodule

// File: rtl/barrett_modinv_3373.sv
// Sequential inverter over GF(3373): a^(q-2) by left-to-right square-and-multiply.
// Optional macro MODINV_ZERO_ERR_EN adds out_err and a short path for a zero operand.
module barrett_modinv_3373
  import modarith_3373_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_r
`ifdef MODINV_ZERO_ERR_EN
  ,
  output logic        out_err
`endif
);

  state_t      state_q, state_d;
  coeff_t      acc_q, acc_d;
  coeff_t      base_q, base_d;
  logic [3:0]  idx_q, idx_d;
  coeff_t      out_r_q, out_r_d;
  logic        out_valid_q, out_valid_d;
  coeff_t      a_red;
  coeff_t      mul_b;
  prod_t       prod;
  coeff_t      red_out;
`ifdef MODINV_ZERO_ERR_EN
  logic        err_q, err_d;
  logic        err_pend_q, err_pend_d;
`endif

  // One shared reducer; the multiplier operand switches between acc and base.
  always_comb begin
    a_red = (in_a >= 12'(Q)) ? (in_a - 12'(Q)) : in_a;
    mul_b = (state_q == MUL) ? base_q : acc_q;
    prod  = prod_t'(acc_q) * prod_t'(mul_b);
  end

  barrett_red24_3373 u_red (
    .x (prod),
    .r (red_out)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    base_d      = base_q;
    idx_d       = idx_q;
    out_r_d     = out_r_q;
    out_valid_d = out_valid_q;
`ifdef MODINV_ZERO_ERR_EN
    err_d       = err_q;
    err_pend_d  = err_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          base_d  = a_red;
          acc_d   = 12'd1;
          idx_d   = 4'd11;
          state_d = SQR;
`ifdef MODINV_ZERO_ERR_EN
          err_d = (a_red == 12'd0);
          if (a_red == 12'd0) begin
            acc_d      = 12'd0;
            err_pend_d = 1'b1;
            state_d    = DONE;
          end
`endif
        end
      end
      SQR: begin
        acc_d = red_out;
        if (EXP[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == 4'd0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - 4'd1;
        end
      end
      MUL: begin
        acc_d = red_out;
        if (idx_q == 4'd0) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q - 4'd1;
          state_d = SQR;
        end
      end
      DONE: begin
        // First DONE cycle registers the result; afterwards wait for the consumer.
        if (!out_valid_q) begin
`ifdef MODINV_ZERO_ERR_EN
          if (err_pend_q) begin
            err_pend_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            out_r_d     = acc_q;
          end
`else
          out_valid_d = 1'b1;
          out_r_d     = acc_q;
`endif
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef MODINV_ZERO_ERR_EN
          err_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef MODINV_ZERO_ERR_EN
      err_q       <= 1'b0;
      err_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
`ifdef MODINV_ZERO_ERR_EN
      err_q       <= err_d;
      err_pend_q  <= err_pend_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
`ifdef MODINV_ZERO_ERR_EN
  assign out_err   = err_q;
`endif

endmodule

// File: tb/tb_barrett_modinv_3373.sv
// Directed and sweep bench for barrett_modinv_3373 with a queue scoreboard.
// Expected inverses come from an extended-Euclid model independent of the DUT.
module tb_barrett_modinv_3373;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_r;
`ifdef MODINV_ZERO_ERR_EN
  logic        out_err;
`endif

  typedef struct {
    int a;
    int r;
    bit err;
  } exp_t;

  exp_t sb[$];
  int   compCount = 0;
  int   errCount  = 0;

  barrett_modinv_3373 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r)
`ifdef MODINV_ZERO_ERR_EN
    ,
    .out_err   (out_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference inverse by extended Euclid; zero maps to zero like Fermat does.
  function automatic int modInv(input int a);
    int r0, r1, t0, t1, qt, tmp;
    r0 = 3373;
    r1 = a % 3373;
    t0 = 0;
    t1 = 1;
    if (r1 == 0) return 0;
    while (r1 != 0) begin
      qt  = r0 / r1;
      tmp = r0 - qt * r1; r0 = r1; r1 = tmp;
      tmp = t0 - qt * t1; t0 = t1; t1 = tmp;
    end
    if (t0 < 0) t0 += 3373;
    return t0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compCount++;
    assert (obs === expv)
    else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Waits for in_ready, performs one accept and records the expected result.
  task automatic applyStimulus(input int a, input int expR, input bit expErr);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) checkVal("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_a     = 12'(a);
    tick();
    in_valid = 1'b0;
    e.a   = a;
    e.r   = expR;
    e.err = expErr;
    sb.push_back(e);
  endtask

  // Waits for out_valid, compares against the scoreboard head and completes the handshake.
  task automatic checkOutput(input int expLatency, input bit randomReady);
    int n;
    exp_t e;
    bit done;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    checkVal("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    if (expLatency >= 0) checkVal("latency", n, expLatency);
    if (sb.size() == 0) begin
      checkVal("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      checkVal($sformatf("out_r a=%0d", e.a), {20'd0, out_r}, e.r);
      if (e.a % 3373 != 0)
        checkVal($sformatf("inv_product a=%0d", e.a), (e.a * int'(out_r)) % 3373, 1);
`ifdef MODINV_ZERO_ERR_EN
      checkVal($sformatf("out_err a=%0d", e.a), {31'd0, out_err}, {31'd0, e.err});
`endif
    end
    done = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      out_ready = randomReady ? ($urandom_range(7) != 0) : 1'b1;
      done = out_ready;
      tick();
      n++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    checkVal("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("reset_out_r", {20'd0, out_r}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] directed operands");
    applyStimulus(1, 1, 1'b0);
    checkOutput(20, 1'b0);
    applyStimulus(2, 1687, 1'b0);
    checkOutput(20, 1'b0);
    applyStimulus(3, 2249, 1'b0);
    checkOutput(20, 1'b0);
    applyStimulus(3372, 3372, 1'b0);
    checkOutput(20, 1'b0);
    applyStimulus(3374, 1, 1'b0);
    checkOutput(20, 1'b0);
    applyStimulus(3373, 0, 1'b1);
`ifdef MODINV_ZERO_ERR_EN
    checkOutput(2, 1'b0);
`else
    checkOutput(20, 1'b0);
`endif

    $display("[TB] backpressure hold");
    applyStimulus(7, 482, 1'b0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 200) begin
        tick();
        n++;
      end
      checkVal("bp_latency", n, 20);
      e = sb.pop_front();
      for (int i = 0; i < 50; i++) begin
        in_valid = 1'b1;
        in_a     = 12'd9;
        checkVal("bp_out_r", {20'd0, out_r}, e.r);
        checkVal("bp_out_valid", {31'd0, out_valid}, 32'd1);
        checkVal("bp_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkVal("bp_release_valid", {31'd0, out_valid}, 32'd0);
      checkVal("bp_release_ready", {31'd0, in_ready}, 32'd1);
      tick();
      checkVal("bp_no_extra_op", {31'd0, out_valid}, 32'd0);
    end

    $display("[TB] reset mid-operation");
    applyStimulus(5, 2024, 1'b0);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    checkVal("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    checkVal("midrst_out_r", {20'd0, out_r}, 32'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    repeat (25) tick();
    checkVal("midrst_no_output", {31'd0, out_valid}, 32'd0);
    applyStimulus(5, 2024, 1'b0);
    checkOutput(20, 1'b0);

    $display("[TB] zero operand");
    applyStimulus(0, 0, 1'b1);
`ifdef MODINV_ZERO_ERR_EN
    checkOutput(2, 1'b0);
`else
    checkOutput(20, 1'b0);
`endif

    $display("[TB] sweep 1..3372");
    for (int a = 1; a <= 3372; a++) begin
      applyStimulus(a, modInv(a), 1'b0);
      checkOutput(-1, 1'b1);
    end

    checkVal("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule

// File: doc/barrett_modinv_3373.md
Name: barrett_modinv_3373

Overview:
- Sequential modular inverter over GF(3373): returns a^-1 mod 3373 via Fermat, a^(q-2) = a^3371, computed with left-to-right square-and-multiply.
- Every modular product goes through an internal Barrett reducer using the team's constant mu = 4973 (2^24 / 3373).
- This is the inverse-direction companion to the combinational reduction path. It sits beside the NTT/arith datapath and feeds divisions and normalisation.
- Valid/ready on both sides; one operation in flight.

Parameters:
- Q, 3373, prime modulus; fixed for this instance.
- MU, 4973, Barrett constant floor(2^24/Q).
- EXP, 3371, exponent Q-2, binary 1101_0010_1011.
- EXP_W, 12, exponent bit count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block idle; can accept an operand.
- in_a  in  12  operand, 0..4095 (need not be reduced).
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_r  out  12  a^-1 mod Q, range 0..3372.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - rst_n low forces state IDLE, in_ready=1, out_valid=0, out_r=0.
  - Accumulator, base and bit index clear.
  - Reset mid-operation aborts the operation silently; no partial output.
- States: IDLE -> SQR <-> MUL -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: base <= (in_a >= Q) ? in_a-Q : in_a; acc <= 1; idx <= 11; go to SQR.
- SQR: acc <= red(acc*acc).
  - If EXP[idx]=1, go to MUL.
  - Else if idx==0, go to DONE.
  - Else idx <= idx-1 and stay in SQR.
- MUL: acc <= red(acc*base).
  - If idx==0, go to DONE; else idx <= idx-1 and go to SQR.
- Operation count and latency:
  - 12 squares + 7 multiplies = 19 op cycles.
  - out_valid rises exactly 20 clocks after the accept edge: 19 ops, then the DONE register load.
- DONE:
  - out_valid=1, out_r=acc, in_ready=0.
  - out_valid&&out_ready returns to IDLE with out_valid=0 the next cycle.
  - No accept occurs in the same cycle as the output handshake.
- Backpressure: out_r and out_valid are stable while out_ready=0, for an unbounded time.
- in_valid outside IDLE is ignored; in_ready=0 in SQR, MUL and DONE.
- Arithmetic:
  - Product is 24 bits (max 3372^2 = 11,370,384 exceeds 23 bits).
  - Barrett: t = ((x>>12)*MU)>>12 (25-bit intermediate), r = x - t*Q.
  - Up to two conditional subtractions of Q; the result is always < Q.
- Boundaries:
  - in_a = 0 or 3373 yields 0 (0 has no inverse; Fermat gives 0).
  - in_a = 1 or 3374 yields 1.

Optional Feature:
- Macro MODINV_ZERO_ERR_EN.
- Defined:
  - Adds output port out_err (1 bit), valid with out_valid, set when the reduced operand == 0.
  - A zero operand skips the exponentiation: goes IDLE -> DONE directly, out_valid 2 clocks after accept, out_r=0, out_err=1.
  - out_err resets to 0.
- Undefined:
  - No out_err port.
  - A zero operand runs the full 20-clock path and returns 0.

Decomposition:
- Shared package (modarith_3373_pkg):
  - Constants Q, MU, EXP, EXP_W, RED_SHIFT=12.
  - Typedef coeff_t (12-bit).
  - Typedef prod_t (24-bit).
  - State enum {IDLE, SQR, MUL, DONE}.
- Sub-module: barrett_red24_3373.
  - Combinational, 24-bit in -> 12-bit out, with two correction stages.
  - Instantiated once, muxed between acc*acc and acc*base.
  - Verified standalone against x mod Q for all x in 0..3372^2.

Test Plan:
- Reset, then in_a=1 -> out_r=1, out_valid high exactly 20 clocks after the accept edge.
- in_a=2 -> 1687; in_a=3 -> 2249; in_a=3372 -> 3372; in_a=3374 (unreduced) -> 1.
- Hold out_ready=0 for 50 cycles after out_valid: out_r stable, in_ready=0, a second in_valid is ignored; then out_ready=1 -> IDLE next cycle.
- Assert rst_n low at op cycle 10 of in_a=5: outputs go to reset values asynchronously; next op in_a=5 -> 2024 (5*2024 = 10120 = 3*3373+1).
- in_a=0: without macro, out_r=0 at 20 clocks; with MODINV_ZERO_ERR_EN, out_r=0 and out_err=1 at 2 clocks.
- Sweep in_a=1..3372 back-to-back with random out_ready: (in_a*out_r) mod 3373 == 1 for every result.
